// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU.
//   - 6-bit opcode encodings
//   - FSM state enum
//   - flag bundle carried in the output register (c doubles as the
//     architectural carry/borrow register)
package alu_pkg;

  localparam logic [5:0] OP_ADC = 6'b010000;
  localparam logic [5:0] OP_SBB = 6'b010001;
  localparam logic [5:0] OP_ADD = 6'b010010;
  localparam logic [5:0] OP_SUB = 6'b010011;
  localparam logic [5:0] OP_MUL = 6'b010100;
  localparam logic [5:0] OP_CLC = 6'b000000;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_SLL = 6'b110000;
  localparam logic [5:0] OP_SRL = 6'b110001;
  localparam logic [5:0] OP_SRA = 6'b110010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue-side and write-back-side handshake bundle.
//   master: issue stage / write-back consumer (drives operands, outReady)
//   slave : alu_seq (drives inReady, result and flags)
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [5:0]       opCode;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] ans1;
  logic             C;
  logic             V;
  logic             Z;
  logic             N;
  logic             err;

  modport master (
    output inValid, a, b, opCode, outReady,
    input  inReady, outValid, ans1, C, V, Z, N, err
  );

  modport slave (
    input  inValid, a, b, opCode, outReady,
    output inReady, outValid, ans1, C, V, Z, N, err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load operands (ignored while busy)
//   a, b       : multiplicand, multiplier
//   busy       : iterating or holding a finished product
//   done       : product valid this cycle; busy clears on the next edge
//   result     : low WIDTH bits of a*b
// Load on the start edge, WIDTH iterations on the following edges, then done
// is presented for exactly one cycle.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] ITER_N = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic             busy_q, busy_d;

  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == ITER_N);
  assign result = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (busy_q) begin
      if (cnt_q == ITER_N) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
    end else if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on issue and write-back sides.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_if slave (operands/opCode in, result/flags out)
// Single-cycle ops are computed at acceptance and registered; MUL is handed
// to alu_mul_iter. flags_q.c is the architectural carry register.
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | no result held, ready for an op
//   MULT  | multiplier iterating, not ready
//   DONE  | result/flags held until outReady; may chain an op
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] ans1_q, ans1_d;
  alu_flags_t       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic             is_mul;

  logic [WIDTH-1:0] dp_ans;
  alu_flags_t       dp_flags;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic             ci;
  logic             sh_over;
  logic [SHW-1:0]   sh_amt;

  logic             mul_done;
  logic             mul_busy;
  logic [WIDTH-1:0] mul_res;

  assign in_ready = !rst && ((state_q == IDLE) || (state_q == DONE && bus.outReady));
  assign accept   = bus.inValid && in_ready;
  assign is_mul   = (bus.opCode == OP_MUL);

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid_q;
  assign bus.ans1     = ans1_q;
  assign bus.C        = flags_q.c;
  assign bus.V        = flags_q.v;
  assign bus.Z        = flags_q.z;
  assign bus.N        = flags_q.n;
  assign bus.err      = flags_q.err;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_mul),
    .a      (bus.a),
    .b      (bus.b),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_res)
  );

  // Carry-in only for ADC/SBB; ADD/SUB force it to 0.
  assign ci      = ((bus.opCode == OP_ADC) || (bus.opCode == OP_SBB)) ? flags_q.c : 1'b0;
  assign sum_ext = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, ci};
  assign dif_ext = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, ci};
  // WIDTH is a power of two, so b >= WIDTH iff any bit above the shift field is set.
  assign sh_over = |bus.b[WIDTH-1:SHW];
  assign sh_amt  = bus.b[SHW-1:0];

  always_comb begin
    dp_ans       = '0;
    dp_flags     = flags_q;
    dp_flags.v   = 1'b0;
    dp_flags.err = 1'b0;
    unique case (bus.opCode)
      OP_ADC, OP_ADD: begin
        dp_ans     = sum_ext[WIDTH-1:0];
        dp_flags.c = sum_ext[WIDTH];
        dp_flags.v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SBB, OP_SUB: begin
        dp_ans     = dif_ext[WIDTH-1:0];
        dp_flags.c = dif_ext[WIDTH];
        dp_flags.v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                     (dif_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_CLC: dp_flags.c = 1'b0;
      OP_EQ:  dp_ans = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_NE:  dp_ans = {{(WIDTH-1){1'b0}}, (bus.a != bus.b)};
      OP_LE:  dp_ans = {{(WIDTH-1){1'b0}}, (bus.a <= bus.b)};
      OP_GT:  dp_ans = {{(WIDTH-1){1'b0}}, (bus.a >  bus.b)};
      OP_SLL: dp_ans = sh_over ? '0 : (bus.a << sh_amt);
      OP_SRL: dp_ans = sh_over ? '0 : (bus.a >> sh_amt);
      OP_SRA: dp_ans = sh_over ? {WIDTH{bus.a[WIDTH-1]}}
                               : WIDTH'($signed(bus.a) >>> sh_amt);
      OP_MUL: dp_ans = '0;
      default: dp_flags.err = 1'b1;
    endcase
    dp_flags.z = (dp_ans == '0);
    dp_flags.n = dp_ans[WIDTH-1];
  end

  always_comb begin
    state_d     = state_q;
    ans1_d      = ans1_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul) begin
            // Previous result stays on ans1 but is no longer valid.
            state_d     = MULT;
            out_valid_d = 1'b0;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            ans1_d      = dp_ans;
            flags_d     = dp_flags;
          end
        end else if (state_q == DONE && bus.outReady) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      MULT: begin
        if (mul_done) begin
          state_d       = DONE;
          out_valid_d   = 1'b1;
          ans1_d        = mul_res;
          flags_d.v     = 1'b0;
          flags_d.err   = 1'b0;
          flags_d.z     = (mul_res == '0);
          flags_d.n     = mul_res[WIDTH-1];
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ans1_q      <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ans1_q      <= ans1_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=32).
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op on the falling edge, release after the accepting edge.
  task automatic drive_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.inValid = 1'b1;
    bus.opCode  = op;
    bus.a       = av;
    bus.b       = bv;
    @(posedge clk);
    #1;
    bus.inValid = 1'b0;
  endtask

  task automatic drain();
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (bus.inReady !== 1'b0) begin
      bad++; $display("FAIL reset_inready_during_rst got=%b want=0", bus.inReady);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.outValid !== 1'b0 || bus.ans1 !== 32'h0 ||
        {bus.C, bus.V, bus.Z, bus.N, bus.err} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got v=%b ans=%h flags=%b want v=0 ans=0 flags=00000",
                      bus.outValid, bus.ans1, {bus.C, bus.V, bus.Z, bus.N, bus.err});
    end
    total++;
    if (bus.inReady !== 1'b1) begin
      bad++; $display("FAIL reset_inready_after got=%b want=1", bus.inReady);
    end
  endtask

  task automatic test_add_adc();
    bus.outReady = 1'b1;
    drive_op(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    total++;
    if (bus.outValid !== 1'b1 || bus.ans1 !== 32'h0 || bus.C !== 1'b1 || bus.Z !== 1'b1) begin
      bad++; $display("FAIL add_wrap got v=%b ans=%h C=%b Z=%b want v=1 ans=0 C=1 Z=1",
                      bus.outValid, bus.ans1, bus.C, bus.Z);
    end
    total++;
    if (bus.inReady !== 1'b1) begin
      bad++; $display("FAIL done_inready got=%b want=1", bus.inReady);
    end
    drive_op(OP_ADC, 32'h0, 32'h0);
    total++;
    if (bus.outValid !== 1'b1 || bus.ans1 !== 32'h1 || bus.C !== 1'b0 || bus.Z !== 1'b0) begin
      bad++; $display("FAIL adc_chain got v=%b ans=%h C=%b Z=%b want v=1 ans=1 C=0 Z=0",
                      bus.outValid, bus.ans1, bus.C, bus.Z);
    end
    drain();
    total++;
    if (bus.outValid !== 1'b0) begin
      bad++; $display("FAIL retire_idle got v=%b want 0", bus.outValid);
    end
  endtask

  task automatic test_sub();
    bus.outReady = 1'b1;
    drive_op(OP_SUB, 32'd5, 32'd7);
    total++;
    if (bus.ans1 !== 32'hFFFF_FFFE || bus.C !== 1'b1 || bus.N !== 1'b1 || bus.V !== 1'b0) begin
      bad++; $display("FAIL sub_neg got ans=%h C=%b N=%b V=%b want ans=fffffffe C=1 N=1 V=0",
                      bus.ans1, bus.C, bus.N, bus.V);
    end
    drive_op(OP_SBB, 32'd10, 32'd3);
    total++;
    if (bus.ans1 !== 32'd6 || bus.C !== 1'b0 || bus.N !== 1'b0) begin
      bad++; $display("FAIL sbb_borrow got ans=%h C=%b N=%b want ans=6 C=0 N=0",
                      bus.ans1, bus.C, bus.N);
    end
    drive_op(OP_SUB, 32'h8000_0000, 32'h1);
    total++;
    if (bus.ans1 !== 32'h7FFF_FFFF || bus.V !== 1'b1 || bus.C !== 1'b0) begin
      bad++; $display("FAIL sub_ovf got ans=%h V=%b C=%b want ans=7fffffff V=1 C=0",
                      bus.ans1, bus.V, bus.C);
    end
    drive_op(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    total++;
    if (bus.ans1 !== 32'h8000_0000 || bus.V !== 1'b1 || bus.N !== 1'b1) begin
      bad++; $display("FAIL add_ovf got ans=%h V=%b N=%b want ans=80000000 V=1 N=1",
                      bus.ans1, bus.V, bus.N);
    end
    drain();
  endtask

  task automatic test_shift_cmp();
    bus.outReady = 1'b1;
    drive_op(OP_SRA, 32'h8000_0000, 32'd4);
    total++;
    if (bus.ans1 !== 32'hF800_0000 || bus.V !== 1'b0) begin
      bad++; $display("FAIL sra_4 got ans=%h V=%b want ans=f8000000 V=0", bus.ans1, bus.V);
    end
    drive_op(OP_SRA, 32'h8000_0000, 32'd40);
    total++;
    if (bus.ans1 !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sra_over got ans=%h want ffffffff", bus.ans1);
    end
    drive_op(OP_SLL, 32'hFFFF_FFFF, 32'd32);
    total++;
    if (bus.ans1 !== 32'h0 || bus.Z !== 1'b1) begin
      bad++; $display("FAIL sll_over got ans=%h Z=%b want ans=0 Z=1", bus.ans1, bus.Z);
    end
    drive_op(OP_SRL, 32'h0000_00F0, 32'd4);
    total++;
    if (bus.ans1 !== 32'h0000_000F) begin
      bad++; $display("FAIL srl_4 got ans=%h want 0000000f", bus.ans1);
    end
    drive_op(OP_SLL, 32'h0000_0003, 32'd31);
    total++;
    if (bus.ans1 !== 32'h8000_0000) begin
      bad++; $display("FAIL sll_31 got ans=%h want 80000000", bus.ans1);
    end
    drive_op(OP_EQ, 32'd5, 32'd5);
    total++;
    if (bus.ans1 !== 32'd1) begin
      bad++; $display("FAIL eq got ans=%h want 1", bus.ans1);
    end
    drive_op(OP_NE, 32'd3, 32'd3);
    total++;
    if (bus.ans1 !== 32'd0) begin
      bad++; $display("FAIL ne got ans=%h want 0", bus.ans1);
    end
    drive_op(OP_LE, 32'd7, 32'd3);
    total++;
    if (bus.ans1 !== 32'd0) begin
      bad++; $display("FAIL le got ans=%h want 0", bus.ans1);
    end
    drive_op(OP_GT, 32'hFFFF_FFFF, 32'd1);
    total++;
    if (bus.ans1 !== 32'd1) begin
      bad++; $display("FAIL gt_unsigned got ans=%h want 1", bus.ans1);
    end
    drive_op(OP_ADD, 32'hFFFF_FFFF, 32'd2);
    drive_op(OP_CLC, 32'h1234, 32'h5678);
    total++;
    if (bus.ans1 !== 32'h0 || bus.C !== 1'b0) begin
      bad++; $display("FAIL clc got ans=%h C=%b want ans=0 C=0", bus.ans1, bus.C);
    end
    drain();
  endtask

  task automatic test_mul();
    int early;
    bus.outReady = 1'b1;
    drive_op(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    drain();
    drive_op(OP_MUL, 32'h0001_2345, 32'h0000_0100);
    total++;
    if (bus.inReady !== 1'b0 || bus.outValid !== 1'b0) begin
      bad++; $display("FAIL mul_start got rdy=%b v=%b want rdy=0 v=0", bus.inReady, bus.outValid);
    end
    // Disturb inputs while busy; the captured operands must be used.
    bus.inValid = 1'b1;
    bus.opCode  = OP_ADD;
    bus.a       = 32'hDEAD_BEEF;
    bus.b       = 32'h0;
    early = 0;
    for (int i = 1; i <= WIDTH; i++) begin
      @(posedge clk);
      #1;
      if (bus.inReady !== 1'b0 || bus.outValid !== 1'b0) early++;
      if (i == WIDTH) bus.inValid = 1'b0;
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL mul_busy_window got bad_cycles=%0d want 0", early);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.outValid !== 1'b1 || bus.ans1 !== 32'h0123_4500 || bus.C !== 1'b1 || bus.err !== 1'b0) begin
      bad++; $display("FAIL mul_result got v=%b ans=%h C=%b err=%b want v=1 ans=01234500 C=1 err=0",
                      bus.outValid, bus.ans1, bus.C, bus.err);
    end
    drain();
  endtask

  task automatic test_hold_undef();
    int moved;
    bus.outReady = 1'b0;
    drive_op(OP_ADD, 32'd3, 32'd4);
    @(negedge clk);
    bus.inValid = 1'b1;
    bus.opCode  = OP_ADD;
    bus.a       = 32'd1;
    bus.b       = 32'd1;
    moved = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.ans1 !== 32'd7 || bus.outValid !== 1'b1 || bus.inReady !== 1'b0 ||
          {bus.C, bus.V, bus.Z, bus.N, bus.err} !== 5'b0) moved++;
    end
    bus.inValid = 1'b0;
    total++;
    if (moved != 0) begin
      bad++; $display("FAIL hold_stable got bad_cycles=%0d want 0 (ans=%h)", moved, bus.ans1);
    end
    drain();
    drive_op(6'h3F, 32'h55, 32'hAA);
    total++;
    if (bus.ans1 !== 32'h0 || bus.err !== 1'b1 || bus.Z !== 1'b1) begin
      bad++; $display("FAIL undef got ans=%h err=%b Z=%b want ans=0 err=1 Z=1",
                      bus.ans1, bus.err, bus.Z);
    end
    drive_op(OP_EQ, 32'h1, 32'h2);
    total++;
    if (bus.err !== 1'b0) begin
      bad++; $display("FAIL err_clear got err=%b want 0", bus.err);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    int spurious;
    bus.outReady = 1'b1;
    drive_op(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    drain();
    drive_op(OP_MUL, 32'h0001_2345, 32'h0000_0100);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.outValid !== 1'b0 || bus.ans1 !== 32'h0 ||
        {bus.C, bus.V, bus.Z, bus.N, bus.err} !== 5'b0 || bus.inReady !== 1'b0) begin
      bad++; $display("FAIL rst_mid_mul got v=%b ans=%h flags=%b rdy=%b want v=0 ans=0 flags=00000 rdy=0",
                      bus.outValid, bus.ans1, {bus.C, bus.V, bus.Z, bus.N, bus.err}, bus.inReady);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.inReady !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready got=%b want 1", bus.inReady);
    end
    drive_op(OP_ADC, 32'd1, 32'd1);
    total++;
    if (bus.ans1 !== 32'd2 || bus.C !== 1'b0) begin
      bad++; $display("FAIL adc_after_rst got ans=%h C=%b want ans=2 C=0", bus.ans1, bus.C);
    end
    drain();
    spurious = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.outValid !== 1'b0) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++; $display("FAIL mul_discarded got valid_cycles=%0d want 0", spurious);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    bus.opCode   = 6'h0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add_adc();
    test_sub();
    test_shift_cmp();
    test_mul();
    test_hold_undef();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational datapath ALU. Accepts one operation per handshake, holds the carry/borrow in a true architectural flag register instead of a feedback latch, and adds plain add/subtract, clear-carry, and an iterative multiply. It sits between the control unit's issue stage and the register-file write-back, with valid/ready on both sides.

## Interface
- WIDTH, 32: operand and result width, ≥ 4, power of two
- SHW, $clog2(WIDTH): shift-amount bits, derived, not overridden
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inValid  in  1  operation offered
- inReady  out  1  operation accepted this cycle when inValid && inReady
- a, b  in  WIDTH  operands
- opCode  in  6  operation select
- outValid  out  1  result registers valid
- outReady  in  1  consumer takes result when outValid && outReady
- ans1  out  WIDTH  result
- C, V, Z, N  out  1 each  carry/borrow, signed overflow, zero, negative
- err  out  1  result came from an undefined opCode

## Operation
- Opcodes: 010000 ADC, 010001 SBB, 010010 ADD, 010011 SUB, 010100 MUL, 000000 CLC, 100000 EQ, 100001 NE, 100010 LE, 100011 GT, 110000 SLL, 110001 SRL, 110010 SRA. Anything else is undefined.
- ADC: t = {0,a} + {0,b} + c (WIDTH+1 bits); ans1 = t[WIDTH-1:0]; c ← t[WIDTH].
- ADD: same as ADC, carry-in forced to 0.
- SBB: t = {0,a} − {0,b} − c; ans1 = low bits; c ← t[WIDTH], i.e. borrow. SUB: same, c-in forced to 0.
- V: two's-complement overflow for ADC/ADD/SBB/SUB; 0 for all other ops.
- CLC: ans1 = 0, c ← 0.
- EQ/NE/LE/GT: unsigned compare; ans1 = 1 or 0, zero-extended.
- Shifts use b[SHW-1:0] only when b < WIDTH.
  - When b ≥ WIDTH: SLL/SRL give 0, SRA gives WIDTH copies of a[WIDTH-1].
  - SRA is a true arithmetic shift of signed a.
- MUL: unsigned shift-add over WIDTH iterations; ans1 = low WIDTH bits of a×b; c unchanged.
- Undefined opCode: ans1 = 0, err = 1, c unchanged. err = 0 for every defined op.
- C output always mirrors the internal c register. Only ADC/ADD/SBB/SUB/CLC write c.
- Z = (ans1 == 0); N = ans1[WIDTH-1]. Both are computed from the registered result.
- State machine:
  - IDLE → DONE on accepting any non-MUL op.
  - IDLE → MULT on accepting MUL.
  - MULT → DONE after WIDTH iterations.
  - DONE → IDLE on outReady without a new accept.
  - DONE → DONE/MULT on outReady with a simultaneous accept.
- inReady = (state==IDLE) || (state==DONE && outReady). It is 0 in MULT.
- Operands and opCode are captured at acceptance. Later input changes have no effect.

## Timing
- Reset (any state, including mid-MUL):
  - Next edge forces IDLE, outValid=0, ans1=0, C=V=Z=N=err=0, c=0, iteration counter=0.
  - An in-flight MUL is discarded.
  - While rst is high, inReady=0 and inputs are ignored.
- Non-MUL latency: accept at edge k → outValid=1 and results stable after edge k.
- MUL latency: accept at edge k → outValid=1 after edge k+WIDTH+1.
- DONE holds ans1 and the flags unchanged until outReady.
- Back-to-back non-MUL ops sustain one result per cycle while outReady=1.
- A flag-writing op accepted in the same cycle its predecessor retires sees the c written by that predecessor (dependent ADC chains work at full rate).
- outReady while outValid=0 has no effect.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_ADC … OP_SRA);
  - state enum {IDLE, MULT, DONE};
  - the flag-bundle struct {C,V,Z,N,err}.
- Sub-module alu_mul_iter (WIDTH parameter) holds:
  - start/busy/done signals;
  - multiplicand, multiplier and accumulator registers;
  - a SHW+1-bit iteration counter.
- The top level holds the combinational single-cycle datapath, the c register, the FSM, and the output registers.

## Test plan
- ADD 0xFFFFFFFF+1, then ADC 0+0 back-to-back → ans1=0, C=1, Z=1; then ans1=1, C=0.
- SUB 5−7 → ans1=0xFFFFFFFE, C=1, N=1; SBB 10−3 → ans1=6, C=0. Also SUB 0x80000000−1 → ans1=0x7FFFFFFF, V=1.
- Shifts:
  - SRA a=0x80000000, b=4 → 0xF8000000;
  - SRA b=40 → 0xFFFFFFFF;
  - SLL b=32 → 0;
  - SRL 0xF0, b=4 → 0x0F.
- MUL 0x12345×0x100 → 0x01234500 after exactly 33 edges. inReady=0 throughout; C is unchanged from its prior value.
- outReady held 0 for 5 cycles after an ADD → ans1 and flags stable, no new accept. Undefined opCode 0x3F → ans1=0, err=1.
- Assert rst at iteration 10 of a MUL → next edge outValid=0, all flags 0, inReady=1 after rst drops; a following ADC 1+1 gives 2 (c=0).
